// File: rtl/ctrl_pipe_cond_if.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_cond_if
//   Bundle of signals between the core datapath/hazard unit and the
//   control-path pipeline ctrl_pipe_cond.
//
//   Optional build macro: CTRL_PIPE_PERF_EN adds SquashCnt / BranchCnt.
//
//   Signals
//     Decode side  : ValidD, CtrlD, RegWriteD, MemWriteD, PCSrcD, MemtoRegD,
//                    BranchD, FlagWriteD[1:0], CondD[3:0]
//     Execute side : ALUFlags[3:0] (NZCV from the ALU), StallE, FlushE
//     Outputs      : CtrlE, CondExE, BranchTakenE, FlagsE, RegWriteM,
//                    MemWriteM, PCSrcW, RegWriteW, MemtoRegW, CtrlW,
//                    ValidDbg[7:0] (bit0 = E valid, bit k = post stage k-1)
//
//   Flow semantics: there is no back-pressure from the pipeline. ValidD
//   qualifies the Decode payload and is captured into E on every cycle that
//   is neither stalled nor flushed. StallE holds E and sends a bubble
//   downstream; FlushE empties E and takes priority over StallE. An
//   instruction leaves E (and may commit) only on a cycle with StallE=0.
// ---------------------------------------------------------------------------
interface ctrl_pipe_cond_if #(
   parameter int CTRL_W = 8
);
   logic              ValidD;
   logic [CTRL_W-1:0] CtrlD;
   logic              RegWriteD;
   logic              MemWriteD;
   logic              PCSrcD;
   logic              MemtoRegD;
   logic              BranchD;
   logic [1:0]        FlagWriteD;
   logic [3:0]        CondD;
   logic [3:0]        ALUFlags;
   logic              StallE;
   logic              FlushE;

   logic [CTRL_W-1:0] CtrlE;
   logic              CondExE;
   logic              BranchTakenE;
   logic [3:0]        FlagsE;
   logic              RegWriteM;
   logic              MemWriteM;
   logic              PCSrcW;
   logic              RegWriteW;
   logic              MemtoRegW;
   logic [CTRL_W-1:0] CtrlW;
   logic [7:0]        ValidDbg;
`ifdef CTRL_PIPE_PERF_EN
   logic [31:0]       SquashCnt;
   logic [31:0]       BranchCnt;
`endif

`ifdef CTRL_PIPE_PERF_EN
   modport master (
      output ValidD, CtrlD, RegWriteD, MemWriteD, PCSrcD, MemtoRegD, BranchD,
             FlagWriteD, CondD, ALUFlags, StallE, FlushE,
      input  CtrlE, CondExE, BranchTakenE, FlagsE, RegWriteM, MemWriteM,
             PCSrcW, RegWriteW, MemtoRegW, CtrlW, ValidDbg, SquashCnt, BranchCnt
   );
   modport slave (
      input  ValidD, CtrlD, RegWriteD, MemWriteD, PCSrcD, MemtoRegD, BranchD,
             FlagWriteD, CondD, ALUFlags, StallE, FlushE,
      output CtrlE, CondExE, BranchTakenE, FlagsE, RegWriteM, MemWriteM,
             PCSrcW, RegWriteW, MemtoRegW, CtrlW, ValidDbg, SquashCnt, BranchCnt
   );
`else
   modport master (
      output ValidD, CtrlD, RegWriteD, MemWriteD, PCSrcD, MemtoRegD, BranchD,
             FlagWriteD, CondD, ALUFlags, StallE, FlushE,
      input  CtrlE, CondExE, BranchTakenE, FlagsE, RegWriteM, MemWriteM,
             PCSrcW, RegWriteW, MemtoRegW, CtrlW, ValidDbg
   );
   modport slave (
      input  ValidD, CtrlD, RegWriteD, MemWriteD, PCSrcD, MemtoRegD, BranchD,
             FlagWriteD, CondD, ALUFlags, StallE, FlushE,
      output CtrlE, CondExE, BranchTakenE, FlagsE, RegWriteM, MemWriteM,
             PCSrcW, RegWriteW, MemtoRegW, CtrlW, ValidDbg
   );
`endif
endinterface

// File: rtl/ctrl_pipe_cond.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_cond
//   Control-path pipeline of the pipelined ARM core. Decoded control enters
//   the Execute register, is qualified by the ARM condition field against
//   the architectural NZCV register, and then shifts through POST_STAGES
//   unstallable registers (M .. W).
//
//   Optional build macro: CTRL_PIPE_PERF_EN (squash / taken-branch counters).
//
//   Parameters
//     CTRL_W      : width of the side-band control bundle (piped unmodified)
//     POST_STAGES : registers after Execute, legal range 2..6
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous active-low reset
//     bus   : ctrl_pipe_cond_if.slave (Decode inputs, Execute controls,
//             E/M/W outputs, stage valid debug vector)
// ---------------------------------------------------------------------------
module ctrl_pipe_cond #(
   parameter int CTRL_W      = 8,
   parameter int POST_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   ctrl_pipe_cond_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic              reg_write;
      logic              mem_write;
      logic              pc_src;
      logic              mem_to_reg;
      logic              branch;
      logic [1:0]        flag_write;
      logic [3:0]        cond;
   } e_stage_t;

   e_stage_t e_q, e_d;
   logic [3:0] flags_q, flags_d;

   // Post-Execute stages: index 0 is M, index POST_STAGES-1 is W.
   logic [POST_STAGES-1:0] valid_q;
   logic [POST_STAGES-1:0] reg_write_q;
   logic [POST_STAGES-1:0] pc_src_q;
   logic [POST_STAGES-1:0] mem_to_reg_q;
   logic [CTRL_W-1:0]      ctrl_q [POST_STAGES];
   logic                   mem_write_m_q;

   logic              valid_m_d;
   logic              reg_write_m_d;
   logic              mem_write_m_d;
   logic              pc_src_m_d;
   logic              mem_to_reg_m_d;
   logic [CTRL_W-1:0] ctrl_m_d;

   logic cond_pass;
   logic cond_ex;
   logic exit_e;
   logic [7:0] valid_dbg;

   logic flag_n, flag_z, flag_c, flag_v;
   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

   always_comb begin : cond_decode
      cond_pass = 1'b0;
      case (e_q.cond)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign cond_ex = e_q.valid & cond_pass;
   // The instruction in E only leaves (and commits) on an unstalled cycle.
   assign exit_e  = ~bus.StallE;

   always_comb begin : e_next
      e_d = e_q;
      if (bus.FlushE) begin
         e_d = '0;
      end else if (!bus.StallE) begin
         e_d.valid      = bus.ValidD;
         e_d.ctrl       = bus.CtrlD;
         e_d.reg_write  = bus.RegWriteD;
         e_d.mem_write  = bus.MemWriteD;
         e_d.pc_src     = bus.PCSrcD;
         e_d.mem_to_reg = bus.MemtoRegD;
         e_d.branch     = bus.BranchD;
         e_d.flag_write = bus.FlagWriteD;
         e_d.cond       = bus.CondD;
      end
   end

   // A stalled E sends an all-zero bubble into M so the held instruction
   // commits once, on its final unstalled cycle.
   always_comb begin : m_next
      valid_m_d      = 1'b0;
      reg_write_m_d  = 1'b0;
      mem_write_m_d  = 1'b0;
      pc_src_m_d     = 1'b0;
      mem_to_reg_m_d = 1'b0;
      ctrl_m_d       = '0;
      if (exit_e) begin
         valid_m_d      = e_q.valid;
         reg_write_m_d  = e_q.reg_write & cond_ex;
         mem_write_m_d  = e_q.mem_write & cond_ex;
         pc_src_m_d     = e_q.pc_src & cond_ex;
         mem_to_reg_m_d = e_q.mem_to_reg;
         ctrl_m_d       = e_q.ctrl;
      end
   end

   always_comb begin : flags_next
      flags_d = flags_q;
      if (cond_ex && exit_e) begin
         if (e_q.flag_write[1]) flags_d[3:2] = bus.ALUFlags[3:2];
         if (e_q.flag_write[0]) flags_d[1:0] = bus.ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q           <= '0;
         flags_q       <= '0;
         valid_q       <= '0;
         reg_write_q   <= '0;
         pc_src_q      <= '0;
         mem_to_reg_q  <= '0;
         mem_write_m_q <= 1'b0;
         for (int i = 0; i < POST_STAGES; i++) ctrl_q[i] <= '0;
      end else begin
         e_q           <= e_d;
         flags_q       <= flags_d;
         valid_q       <= {valid_q[POST_STAGES-2:0], valid_m_d};
         reg_write_q   <= {reg_write_q[POST_STAGES-2:0], reg_write_m_d};
         pc_src_q      <= {pc_src_q[POST_STAGES-2:0], pc_src_m_d};
         mem_to_reg_q  <= {mem_to_reg_q[POST_STAGES-2:0], mem_to_reg_m_d};
         mem_write_m_q <= mem_write_m_d;
         ctrl_q[0]     <= ctrl_m_d;
         for (int i = 1; i < POST_STAGES; i++) ctrl_q[i] <= ctrl_q[i-1];
      end
   end

   always_comb begin : dbg_pack
      valid_dbg    = '0;
      valid_dbg[0] = e_q.valid;
      for (int i = 0; i < POST_STAGES; i++) valid_dbg[i+1] = valid_q[i];
   end

   assign bus.CtrlE        = e_q.ctrl;
   assign bus.CondExE      = cond_ex;
   assign bus.BranchTakenE = e_q.branch & cond_ex;
   assign bus.FlagsE       = flags_q;
   assign bus.RegWriteM    = reg_write_q[0];
   assign bus.MemWriteM    = mem_write_m_q;
   assign bus.PCSrcW       = pc_src_q[POST_STAGES-1];
   assign bus.RegWriteW    = reg_write_q[POST_STAGES-1];
   assign bus.MemtoRegW    = mem_to_reg_q[POST_STAGES-1];
   assign bus.CtrlW        = ctrl_q[POST_STAGES-1];
   assign bus.ValidDbg     = valid_dbg;

`ifdef CTRL_PIPE_PERF_EN
   logic [31:0] squash_cnt_q, squash_cnt_d;
   logic [31:0] branch_cnt_q, branch_cnt_d;

   // Counted at unstalled exit so a held instruction is counted once.
   always_comb begin : perf_next
      squash_cnt_d = squash_cnt_q;
      branch_cnt_d = branch_cnt_q;
      if (exit_e && e_q.valid && !cond_pass && (squash_cnt_q != 32'hFFFF_FFFF))
         squash_cnt_d = squash_cnt_q + 32'd1;
      if (exit_e && e_q.branch && cond_ex && (branch_cnt_q != 32'hFFFF_FFFF))
         branch_cnt_d = branch_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         squash_cnt_q <= '0;
         branch_cnt_q <= '0;
      end else begin
         squash_cnt_q <= squash_cnt_d;
         branch_cnt_q <= branch_cnt_d;
      end
   end

   assign bus.SquashCnt = squash_cnt_q;
   assign bus.BranchCnt = branch_cnt_q;
`endif

endmodule

// File: doc/ctrl_pipe_cond.md
Name: ctrl_pipe_cond

Overview:
- Parametrised control-path pipeline for the pipelined ARM core.
- Carries decoded control from Decode through Execute and a configurable number of post-Execute stages, ending at Writeback.
- Evaluates all 15 ARM condition codes in Execute against an internal NZCV flags register and squashes side effects of failed instructions.
- Supports stall and flush of the Execute register, a valid bit per stage, and a generic side-band control bundle of configurable width.

Parameters:
- CTRL_W, 8: width of the generic control bundle (ALU control, src selects, etc.) piped D->E->...->W unmodified.
- POST_STAGES, 2: number of register stages after Execute (M..W); legal range 2..6.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ValidD  in  1  Decode stage holds a real instruction.
- CtrlD  in  CTRL_W  generic control bundle.
- RegWriteD / MemWriteD / PCSrcD / MemtoRegD / BranchD  in  1 each  decoded control.
- FlagWriteD  in  2  bit1: write N,Z; bit0: write C,V.
- CondD  in  4  condition field.
- ALUFlags  in  4  NZCV from ALU in Execute.
- StallE  in  1  hold Execute register.
- FlushE  in  1  clear Execute register.
- CtrlE  out  CTRL_W  bundle in Execute.
- CondExE  out  1  Execute instruction valid and condition passes.
- BranchTakenE  out  1  BranchE & CondExE.
- FlagsE  out  4  architectural NZCV register.
- RegWriteM / MemWriteM  out  1  gated controls in first post stage.
- PCSrcW / RegWriteW / MemtoRegW  out  1  controls at last stage.
- CtrlW  out  CTRL_W  bundle at last stage.

Behaviour:
- Reset (reset=0, async): all stage registers, valid bits and FlagsE clear to 0; every output is 0.
- E register update priority: FlushE > StallE > load. FlushE loads all-zero (valid=0). StallE holds contents. Otherwise it loads the D inputs, with valid=ValidD.
- Condition decode (CondE vs FlagsE):
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 true; 1111 false.
- CondExE = validE & CondPass. RegWrite, MemWrite and PCSrc are ANDed with CondExE before entering M. MemtoReg and Ctrl pass ungated.
- Flags update at the clock edge that ends the E cycle, only if CondExE & ~StallE:
  - FlagWriteE[1] loads N,Z from ALUFlags[3:2].
  - FlagWriteE[0] loads C,V from ALUFlags[1:0].
  - The next instruction in E sees the new flags in its own cycle (one-cycle latency, no bypass needed).
- StallE=1: first post stage loads a bubble (all zero), so a held instruction commits exactly once, in its final unstalled cycle. Flags are not written while stalled.
- Post-Execute stages are never stalled or flushed; each shifts every cycle. Latency E->W is POST_STAGES cycles. With the default, RegWriteM appears 1 cycle after E and RegWriteW 2 cycles after E.
- Simultaneous FlushE & StallE: flush wins, and the M bubble rule still applies.
- Reset asserted mid-operation: all in-flight instructions are discarded and FlagsE is cleared immediately.

Optional Feature:
- Macro CTRL_PIPE_PERF_EN. When defined, adds outputs:
  - SquashCnt [31:0]: count of valid E instructions with a failed condition, counted once per instruction at unstalled exit.
  - BranchCnt [31:0]: count of BranchTakenE at unstalled exit.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, no stimulus -> all outputs 0 and FlagsE=0000 for 5 cycles.
- Load ValidD=1, FlagWriteD=11, CondD=1110, ALUFlags=0100 -> FlagsE=0100 next cycle. Then CondD=0000 (EQ), RegWriteD=1 -> RegWriteM=1 and RegWriteW=1 two cycles after E.
- With FlagsE=0100, issue NE instruction with MemWriteD=1, RegWriteD=1 -> CondExE=0, MemWriteM=0, RegWriteW=0, FlagsE unchanged despite FlagWriteD=11.
- BranchD=1, CondD=1010 (GE) with FlagsE N=1,V=1 -> BranchTakenE=1 for exactly one cycle. Then FlushE=1 -> next E contents zero and no M/W commits.
- StallE=1 for 3 cycles with a RegWrite instruction in E -> RegWriteM=0 during the stall, then exactly one RegWriteM=1 pulse after release.
- POST_STAGES=4 build with CTRL_PIPE_PERF_EN: 3 failed-condition and 2 taken branches -> RegWriteW latency 4 cycles, SquashCnt=3, BranchCnt=2.
